// File: rtl/uart_pkg.sv
// Shared types and CSR bit positions for the UART transmit/receive blocks.
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  localparam int CSR_GO      = 0;
  localparam int CSR_PAR_EN  = 1;
  localparam int CSR_PAR_ODD = 2;
  localparam int CSR_STOP2   = 3;

endpackage

`default_nettype wire

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while run is high, ticks on terminal count.
`default_nettype none

module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  logic [CNT_W-1:0] cnt;

  assign tick = run && (cnt == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || !run) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// UART transmitter: launches one 8-bit frame (optional parity, 1 or 2 stop bits) per GO rising edge.
`default_nettype none

module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] uart_io_reg,
  input  logic [31:0] uart_csr_reg,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  uart_tx_state_t state, state_d;

  logic       go_q;
  logic       start;
  logic       tick;
  logic       load;
  logic [7:0] byte_q;
  logic       par_en_q, par_odd_q, stop2_q;
  logic [2:0] idx, idx_d, idx_nx;
  logic       stop_cnt, stop_cnt_d;
  logic       tx_d, busy_d, done_d, overrun_d;
  logic       unused_bits;

  assign unused_bits = ^{uart_io_reg[31:8], uart_csr_reg[31:4]};
  assign start       = uart_csr_reg[CSR_GO] & ~go_q;
  assign idx_nx      = idx + 3'd1;

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (state != IDLE),
    .tick  (tick)
  );

  // go_q resets high so a GO already asserted through reset is not seen as an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      go_q      <= 1'b1;
      byte_q    <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      stop2_q   <= 1'b0;
    end else begin
      go_q <= uart_csr_reg[CSR_GO];
      if (load) begin
        byte_q    <= uart_io_reg[7:0];
        par_en_q  <= uart_csr_reg[CSR_PAR_EN];
        par_odd_q <= uart_csr_reg[CSR_PAR_ODD];
        stop2_q   <= uart_csr_reg[CSR_STOP2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      stop_cnt <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_d;
      idx      <= idx_d;
      stop_cnt <= stop_cnt_d;
      tx       <= tx_d;
      busy     <= busy_d;
      done     <= done_d;
      overrun  <= overrun_d;
    end
  end

  // Next-state logic also chooses the next tx level so the pin comes straight from a flop.
  always_comb begin
    state_d    = state;
    idx_d      = idx;
    stop_cnt_d = stop_cnt;
    tx_d       = tx;
    busy_d     = busy;
    done_d     = 1'b0;
    overrun_d  = overrun;
    load       = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_d    = START;
          load       = 1'b1;
          idx_d      = '0;
          stop_cnt_d = 1'b0;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
          overrun_d  = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          idx_d   = '0;
          tx_d    = byte_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (idx == 3'd7) begin
            stop_cnt_d = 1'b0;
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = ^byte_q ^ par_odd_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d = idx_nx;
            tx_d  = byte_q[idx_nx];
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d    = STOP;
          stop_cnt_d = 1'b0;
          tx_d       = 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          if (stop2_q && !stop_cnt) begin
            stop_cnt_d = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        tx_d    = 1'b1;
      end
    endcase

    if (start && state != IDLE) begin
      overrun_d = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with a bit-level scoreboard; second instance covers the 434-cycle baud.
`default_nettype none

module tb_uart_tx;

  localparam int CPB  = 4;
  localparam int CPB2 = 434;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] io_a, csr_a, io_b, csr_b;
  logic        tx_a, busy_a, done_a, ovr_a;
  logic        tx_b, busy_b, done_b, ovr_b;

  int n_checks = 0;
  int n_pass   = 0;

  logic bit_q[$];
  int   len_q[$];

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .uart_io_reg(io_a), .uart_csr_reg(csr_a),
    .tx(tx_a), .busy(busy_a), .done(done_a), .overrun(ovr_a)
  );

  uart_tx #(.CLKS_PER_BIT(CPB2), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .uart_io_reg(io_b), .uart_csr_reg(csr_b),
    .tx(tx_b), .busy(busy_b), .done(done_b), .overrun(ovr_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference frame: start, 8 data LSB first, optional parity, one or two stops.
  task automatic push_frame(input logic [7:0] d, input logic [3:0] ctl);
    bit_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) bit_q.push_back(d[i]);
    if (ctl[1]) bit_q.push_back((^d) ^ ctl[2]);
    bit_q.push_back(1'b1);
    if (ctl[3]) bit_q.push_back(1'b1);
    len_q.push_back(CPB * (10 + int'(ctl[1]) + int'(ctl[3])));
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d, input logic [3:0] ctl,
                           input bit disturb);
    int busy_cnt = 0;
    int done_cnt = 0;
    int k = 0;
    int exp_len;
    logic b;
    push_frame(d, ctl);
    @(negedge clk);
    io_a  = {24'h0, d};
    csr_a = {28'h0, ctl[3:1], 1'b0};
    @(negedge clk);
    csr_a[0] = 1'b1;
    @(negedge clk);
    while (bit_q.size() > 0) begin
      b = bit_q.pop_front();
      for (int c = 0; c < CPB; c++) begin
        check($sformatf("%s_tx_b%0d_c%0d", tag, k, c), tx_a, b);
        if (busy_a) busy_cnt++;
        if (done_a) done_cnt++;
        if (disturb && k == 4 && c == 0) begin
          csr_a[0] = 1'b0;
          io_a     = 32'hFF;
        end
        if (disturb && k == 4 && c == 2) csr_a[0] = 1'b1;
        @(negedge clk);
      end
      k++;
    end
    exp_len = len_q.pop_front();
    check({tag, "_busy_len"}, busy_cnt, exp_len);
    check({tag, "_done_early"}, done_cnt, 0);
    check({tag, "_busy_end"}, busy_a, 1'b0);
    check({tag, "_done_pulse"}, done_a, 1'b1);
    check({tag, "_overrun"}, ovr_a, disturb ? 1'b1 : 1'b0);
    @(negedge clk);
    check({tag, "_done_once"}, done_a, 1'b0);
    busy_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy_a) busy_cnt++;
      @(negedge clk);
    end
    check({tag, "_go_held_no_refire"}, busy_cnt, 0);
    csr_a[0] = 1'b0;
  endtask

  initial begin
    int busy_cnt;
    int low_cnt;
    int guard;
    rst_n = 1'b0;
    io_a = '0; csr_a = '0; io_b = '0; csr_b = '0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx_a, 1'b1);
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_overrun", ovr_a, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    run_frame("t1_55", 8'h55, 4'h0, 1'b0);
    run_frame("t2_a3_even", 8'hA3, 4'h2, 1'b0);
    run_frame("t2_a3_odd_s2", 8'hA3, 4'hE, 1'b0);
    run_frame("t2_a3_even_s2", 8'hA3, 4'hA, 1'b0);
    run_frame("t3_overrun", 8'h55, 4'h0, 1'b1);
    run_frame("t3_clean", 8'h96, 4'h6, 1'b0);

    // GO held high through reset must not start a frame.
    @(negedge clk);
    rst_n = 1'b0;
    csr_a = 32'h1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    busy_cnt = 0; low_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy_a) busy_cnt++;
      if (!tx_a) low_cnt++;
    end
    check("t4_no_busy", busy_cnt, 0);
    check("t4_no_tx_low", low_cnt, 0);
    run_frame("t4_after", 8'hC1, 4'h0, 1'b0);

    // Abort during data bit 3.
    @(negedge clk);
    io_a = 32'h3C; csr_a = 32'h0;
    @(negedge clk);
    csr_a[0] = 1'b1;
    repeat (18) @(negedge clk);
    check("t5_busy_mid", busy_a, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_abort_tx", tx_a, 1'b1);
    check("t5_abort_busy", busy_a, 1'b0);
    check("t5_abort_done", done_a, 1'b0);
    rst_n = 1'b1;
    csr_a = 32'h0;
    @(negedge clk);
    run_frame("t5_after", 8'h3C, 4'h0, 1'b0);

    // 434 clocks per bit, data 0x00: tx low for start + 8 data bits.
    @(negedge clk);
    io_b = 32'h0; csr_b = 32'h0;
    @(negedge clk);
    csr_b[0] = 1'b1;
    @(negedge clk);
    check("t6_start_low", tx_b, 1'b0);
    busy_cnt = 0; low_cnt = 0; guard = 0;
    while (busy_b && guard < 6000) begin
      busy_cnt++;
      if (!tx_b) low_cnt++;
      guard++;
      @(negedge clk);
    end
    check("t6_busy_len", busy_cnt, CPB2 * 10);
    check("t6_low_len", low_cnt, CPB2 * 9);
    check("t6_done", done_b, 1'b1);
    check("t6_overrun", ovr_b, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
